// File: rtl/imm_ext_ctrl.sv
// rtl/imm_ext_ctrl.sv - immediate extraction and sign-extension controller
//
// Purpose: accepts a 16-bit instruction over a valid/ready handshake, decodes
// the opcode class and delivers a 16-bit extended immediate over a second
// valid/ready handshake. Counts delivered immediates modulo 256.
//
// Optional feature: define IMM_LUI_EN to enable the LUI path for opcode 0x8
// (imm_out = {instr[7:0], 8'h00}, one extra cycle of latency). Without it,
// opcode 0x8 yields no immediate.
//
// Ports:
//   CLK          in   1   clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   instr        in  16   instruction word, opcode = instr[15:12]
//   instr_valid  in   1   instr offered
//   instr_ready  out  1   block accepts instr (IDLE only)
//   imm_out      out 16   extended immediate (held outside OUT)
//   imm_sel      out  1   1 = 10-bit mode, 0 = 12-bit or LUI
//   imm_valid    out  1   imm_out/imm_sel valid (OUT only)
//   imm_ready    in   1   consumer takes imm_out
//   busy         out  1   state is not IDLE
//   ext_count    out  8   immediates delivered, modulo 256

module imm_ext_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] imm_out,
  output logic        imm_sel,
  output logic        imm_valid,
  input  logic        imm_ready,
  output logic        busy,
  output logic [7:0]  ext_count
);

`ifdef IMM_LUI_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2,
    LUI    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_out_q, imm_out_d;
  logic        imm_sel_q, imm_sel_d;
  logic [7:0]  ext_count_q, ext_count_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      instr_q     <= 16'h0000;
      imm_out_q   <= 16'h0000;
      imm_sel_q   <= 1'b0;
      ext_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      imm_out_q   <= imm_out_d;
      imm_sel_q   <= imm_sel_d;
      ext_count_q <= ext_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    imm_out_d   = imm_out_q;
    imm_sel_d   = imm_sel_q;
    ext_count_d = ext_count_q;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end

      DECODE: begin
        // imm_out/imm_sel are only written when an immediate will actually be
        // delivered, so the last delivered value survives no-immediate opcodes.
        case (instr_q[15:12])
          4'h4, 4'h5, 4'h6, 4'h7: begin
            imm_out_d = {{6{instr_q[9]}}, instr_q[9:0]};
            imm_sel_d = 1'b1;
            state_d   = OUT;
          end
          4'hC, 4'hD, 4'hE, 4'hF: begin
            imm_out_d = {{4{instr_q[11]}}, instr_q[11:0]};
            imm_sel_d = 1'b0;
            state_d   = OUT;
          end
`ifdef IMM_LUI_EN
          4'h8: begin
            state_d = LUI;
          end
`endif
          default: begin
            state_d = IDLE;
          end
        endcase
      end

`ifdef IMM_LUI_EN
      LUI: begin
        imm_out_d = {instr_q[7:0], 8'h00};
        imm_sel_d = 1'b0;
        state_d   = OUT;
      end
`endif

      OUT: begin
        // Leaving OUT goes to IDLE, never straight to a new capture.
        if (imm_ready) begin
          ext_count_d = ext_count_q + 8'd1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign imm_valid   = (state_q == OUT);
  assign imm_out     = imm_out_q;
  assign imm_sel     = imm_sel_q;
  assign ext_count   = ext_count_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// tb/tb_imm_ext_ctrl.sv - scoreboard testbench for imm_ext_ctrl
module tb_imm_ext_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] imm_out;
  logic        imm_sel;
  logic        imm_valid;
  logic        imm_ready = 1'b0;
  logic        busy;
  logic [7:0]  ext_count;

  imm_ext_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .imm_out     (imm_out),
    .imm_sel     (imm_sel),
    .imm_valid   (imm_valid),
    .imm_ready   (imm_ready),
    .busy        (busy),
    .ext_count   (ext_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] imm;
    logic        sel;
    int          tcyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   rdy_mode = 1;
  bit   in_out = 0;

  always @(posedge CLK) cyc = cyc + 1;

  // Consumer readiness: 0 = random, 1 = always ready, 2 = stalled.
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       imm_ready = ($urandom_range(0, 3) != 0);
      1:       imm_ready = 1'b1;
      default: imm_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: immediate value computed arithmetically from the opcode rules.
  function automatic bit model(input logic [15:0] i, output exp_t e);
    int op;
    int v;
    op     = int'(i[15:12]);
    e.tcyc = 0;
    e.lat  = 2;
    e.sel  = 1'b0;
    e.imm  = 16'h0000;
    if (op >= 4 && op <= 7) begin
      v = int'(i[9:0]);
      if (v >= 512) v = v - 1024;
      e.imm = 16'(v);
      e.sel = 1'b1;
      return 1'b1;
    end
    if (op >= 12) begin
      v = int'(i[11:0]);
      if (v >= 2048) v = v - 4096;
      e.imm = 16'(v);
      return 1'b1;
    end
`ifdef IMM_LUI_EN
    if (op == 8) begin
      e.imm = 16'(int'(i[7:0]) * 256);
      e.lat = 3;
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  // Monitor: compares every presented immediate against the scoreboard head.
  always @(negedge CLK) begin
    if (!reset) begin
      in_out = 0;
    end else begin
      check("ext_count", 32'(ext_count), 32'(model_cnt));
      if (imm_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_imm_valid: got imm_out %0h expected no imm_valid (cycle %0d)", imm_out, cyc);
        end else begin
          if (!in_out) begin
            check("latency", 32'(cyc - sb[0].tcyc), 32'(sb[0].lat));
            in_out = 1;
          end
          check("imm_out", 32'(imm_out), 32'(sb[0].imm));
          check("imm_sel", 32'(imm_sel), 32'(sb[0].sel));
          check("instr_ready_in_out", 32'(instr_ready), 32'd0);
          if (imm_ready) begin
            void'(sb.pop_front());
            in_out = 0;
            model_cnt = (model_cnt + 1) % 256;
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] i);
    exp_t e;
    int   n;
    n = 0;
    @(negedge CLK);
    while (!instr_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!instr_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got instr_ready 0 expected 1 within 100 cycles");
      return;
    end
    instr       = i;
    instr_valid = 1'b1;
    if (model(i, e)) begin
      e.tcyc = cyc;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge CLK);
    while (!imm_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("wait_imm_valid", 32'(imm_valid), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #2;
    reset = 1'b0;
    sb.delete();
    model_cnt = 0;
    @(posedge CLK);
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [15:0] rand_imm_instr();
    int op;
    op = $urandom_range(0, 7);
    op = (op < 4) ? op + 4 : op + 8;
    return {4'(op), 12'($urandom)};
  endfunction

  initial begin
    int cnt0;
    #1 reset = 1'b0;
    #10;
    check("rst_imm_out", 32'(imm_out), 32'h0);
    check("rst_imm_sel", 32'(imm_sel), 32'h0);
    check("rst_imm_valid", 32'(imm_valid), 32'h0);
    check("rst_ext_count", 32'(ext_count), 32'h0);
    check("rst_instr_ready", 32'(instr_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge CLK);
    #2 reset = 1'b1;

    rdy_mode = 1;
    issue(16'h43FC);
    drain();
    check("count_after_first", 32'(ext_count), 32'd1);
    issue(16'hC3FC);
    issue(16'hCA00);
    issue(16'h4200);
    drain();

    // No-immediate opcode: DECODE for one cycle, then straight back to IDLE.
    issue(16'h1234);
    @(negedge CLK);
    check("noimm_decode_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    check("noimm_idle_busy", 32'(busy), 32'd0);
    check("noimm_idle_ready", 32'(instr_ready), 32'd1);

    issue(16'h80A5);
    drain();

    // Backpressure: five stalled cycles in OUT.
    rdy_mode = 2;
    issue(16'h4200);
    wait_valid();
    cnt0 = model_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_valid_held", 32'(imm_valid), 32'd1);
      check("bp_instr_ready", 32'(instr_ready), 32'd0);
      check("bp_count", 32'(ext_count), 32'(cnt0));
    end
    rdy_mode = 1;
    drain();

    // Asynchronous reset while stalled in OUT.
    rdy_mode = 2;
    issue(16'h43FC);
    wait_valid();
    @(posedge CLK);
    #3 reset = 1'b0;
    #1;
    check("arst_imm_out", 32'(imm_out), 32'h0);
    check("arst_imm_sel", 32'(imm_sel), 32'h0);
    check("arst_imm_valid", 32'(imm_valid), 32'h0);
    check("arst_ext_count", 32'(ext_count), 32'h0);
    check("arst_instr_ready", 32'(instr_ready), 32'h1);
    check("arst_busy", 32'(busy), 32'h0);
    sb.delete();
    model_cnt = 0;
    rdy_mode = 1;
    @(posedge CLK);
    #2 reset = 1'b1;
    issue(16'hC3FC);
    drain();

    // Counter wrap: 256 deliveries from a cleared count.
    pulse_reset();
    for (int k = 0; k < 256; k++) issue(rand_imm_instr());
    drain();
    check("wrap_count", 32'(ext_count), 32'h0);

    // Fully random opcodes with random backpressure.
    rdy_mode = 0;
    for (int k = 0; k < 200; k++) issue(16'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: got simulation still running expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_ext_ctrl.md
IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- CLK  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  16  instruction word; opcode = instr[15:12].
- instr_valid  in  1  instr is offered this cycle.
- instr_ready  out  1  block accepts instr this cycle.
- imm_out  out  16  extended immediate.
- imm_sel  out  1  extension mode in use: 1 = 10-bit, 0 = 12-bit or LUI.
- imm_valid  out  1  imm_out and imm_sel are valid.
- imm_ready  in  1  consumer takes imm_out this cycle.
- busy  out  1  state is not IDLE.
- ext_count  out  8  number of immediates delivered, modulo 256.

REQ-002 The block SHALL have no parameters; the widths above are fixed.

Function
REQ-003 The FSM SHALL have the states IDLE, DECODE, LUI and OUT; busy SHALL be 1 in every state other than IDLE.
REQ-004 instr_ready SHALL be 1 only in IDLE; a transfer occurs when instr_valid and instr_ready are both 1, and the block SHALL then capture instr and move to DECODE.
REQ-005 In DECODE, the opcode class SHALL be:
- 0x4-0x7: 10-bit mode; imm_out = sign-extension of instr[9:0] to 16 bits; imm_sel = 1.
- 0xC-0xF: 12-bit mode; imm_out = sign-extension of instr[11:0] to 16 bits; imm_sel = 0.
- 0x8: handled per REQ-016.
- all other opcodes: no immediate.
REQ-006 DECODE SHALL last exactly one cycle, then move to OUT; for a no-immediate opcode it SHALL instead return to IDLE with no imm_valid pulse and no change to ext_count.
REQ-007 imm_valid SHALL be 1 only in OUT, with imm_out and imm_sel registered and held stable for the whole of OUT.
REQ-008 Latency: for a transfer in cycle N, imm_valid SHALL first be 1 in cycle N+2 (N+3 for the LUI path).
REQ-009 OUT SHALL persist while imm_ready = 0; on imm_valid & imm_ready the block SHALL increment ext_count (255 wraps to 0) and return to IDLE.
REQ-010 The block SHALL NOT accept a new instruction in the cycle it leaves OUT; the earliest next transfer is the following cycle, in IDLE.
REQ-011 Changes on instr or instr_valid outside IDLE SHALL have no effect on captured state or outputs.
REQ-012 imm_out SHALL hold its last delivered value while the block is outside OUT.

Reset
REQ-013 reset = 0 SHALL immediately, without waiting for CLK, force state IDLE, imm_out = 16'h0000, imm_sel = 0, imm_valid = 0, ext_count = 8'h00 and the captured instruction to 0; instr_ready SHALL then be 1 and busy 0.
REQ-014 Reset asserted in any state, including OUT with imm_ready = 0, SHALL abandon the operation without incrementing ext_count.
REQ-015 After reset deasserts, the first rising CLK edge SHALL be able to accept an instruction.

Configuration
REQ-016 Macro IMM_LUI_EN SHALL control opcode 0x8:
- Defined: DECODE moves to LUI for one cycle, then to OUT, with imm_out = {instr[7:0], 8'h00} and imm_sel = 0.
- Undefined: the LUI state does not exist and opcode 0x8 is a no-immediate opcode (REQ-006).

Verification
REQ-017 The bench SHALL cover at least these scenarios:
- 10-bit negative: instr = 16'h43FC, valid in cycle N, imm_ready = 1 -> imm_valid in N+2, imm_out = 16'hFFFC, imm_sel = 1, ext_count 0->1.
- 12-bit positive and negative: instr = 16'hC3FC -> 16'h03FC, imm_sel = 0; instr = 16'hCA00 -> 16'hFA00; instr = 16'h4200 -> 16'hFE00.
- Backpressure and no-immediate: hold imm_ready = 0 for 5 cycles in OUT -> imm_out stable, instr_ready = 0, no count change; instr = 16'h1234 -> back to IDLE after DECODE, no imm_valid.
- Async reset in OUT: reset low mid-cycle -> outputs zero before the next CLK edge, ext_count = 0, instr_ready = 1.
- Counter wrap: 256 deliveries -> ext_count returns to 8'h00.
- LUI: instr = 16'h80A5 -> with IMM_LUI_EN defined, imm_out = 16'hA500 at N+3; without it, no imm_valid.
